// File: rtl/attopu_prog_encoder.sv
// Program-building encoder: range-checks symbolic instructions, packs them into
// 16-bit attopu words and streams them into instruction memory, ending with HALT.
module attopu_prog_encoder #(
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               finish,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_kind,
  input  logic [1:0]         in_rd,
  input  logic [1:0]         in_rs1,
  input  logic [1:0]         in_rs2,
  input  logic [6:0]         in_alu_op,
  input  logic [15:0]        in_imm,
  input  logic               in_br_val,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [15:0]        imem_wdata,
  output logic [IMEM_AW:0]   prog_len,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0]      HALT_WORD = 16'hE000;
  localparam logic [IMEM_AW:0] LAST_PTR  = {1'b0, {IMEM_AW{1'b1}}};
  localparam logic [IMEM_AW:0] PTR_ONE   = {{IMEM_AW{1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [IMEM_AW:0]     ptr_q, ptr_d;
  logic                 we_q, we_d;
  logic [IMEM_AW-1:0]   addr_q, addr_d;
  logic [15:0]          wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;
  logic                 done_q, done_d;

  logic [15:0]          enc_word;
  logic                 enc_rej;
  logic [1:0]           enc_code;
  logic                 br_ok;
  logic                 accept;

  // Handshake: a transfer happens on any rising edge where in_valid and in_ready
  // are both high. in_ready depends only on state and pointer, never on in_valid;
  // the last memory word is held back for the terminating HALT.
  assign in_ready = (state_q == S_RUN) && (ptr_q < LAST_PTR);
  assign accept   = in_valid && in_ready;

  // Branch offsets must fit 11-bit two's complement: bits 15..10 all equal.
  assign br_ok = (&in_imm[15:10]) || !(|in_imm[15:10]);

  always_comb begin
    enc_word = '0;
    enc_rej  = 1'b0;
    enc_code = 2'b00;
    case (in_kind)
      3'd0: enc_word = {3'b000, in_rd, in_rs1, in_rs2, in_alu_op};
      3'd1: begin
        enc_word = {3'b001, in_rd, in_imm[10:0]};
        if (|in_imm[15:11]) begin
          enc_rej  = 1'b1;
          enc_code = 2'b01;
        end
      end
      3'd2: enc_word = {3'b011, in_rd, in_rs1, 9'b0};
      3'd3: enc_word = {3'b101, 2'b00, in_rs1, in_rs2, 7'b0};
      3'd4, 3'd5: begin
        enc_word = {3'b110, in_kind[0], in_br_val, in_imm[10:0]};
        if (!br_ok) begin
          enc_rej  = 1'b1;
          enc_code = 2'b01;
        end
      end
      3'd6: enc_word = HALT_WORD;
      default: begin
        enc_rej  = 1'b1;
        enc_code = 2'b10;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    code_d  = code_q;
    done_d  = done_q;
    if (start) begin
      state_d = S_RUN;
      ptr_d   = '0;
      err_d   = 1'b0;
      code_d  = 2'b00;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (accept) begin
            if (enc_rej) begin
              err_d  = 1'b1;
              code_d = enc_code;
            end else begin
              we_d    = 1'b1;
              addr_d  = ptr_q[IMEM_AW-1:0];
              wdata_d = enc_word;
              ptr_d   = ptr_q + PTR_ONE;
            end
          end
          // A same-cycle instruction is written first; HALT follows it.
          if (finish) state_d = S_FIN;
        end
        S_FIN: begin
          we_d    = 1'b1;
          addr_d  = ptr_q[IMEM_AW-1:0];
          wdata_d = HALT_WORD;
          ptr_d   = ptr_q + PTR_ONE;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign prog_len   = ptr_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign dbg_state  = state_q;

endmodule
